entity_pixel_renderer: RTL and testbench

- Consumer end of the per-pixel entity-selection interface (entity code, entity X/Y, direction, lose_game).
- Turns each selected entity into an RGB pixel through a 2-stage pipeline with external sprite ROM reads.
- Owns the sprite animation frame and the PLAY/DYING/OVER game-state FSM driven by lose_game.
- Sits between the entity selector and the VGA output registers.

---
 rtl/entity_pixel_renderer.sv | 235 +++++++++++++++++++++++
 tb/tb_entity_pixel_renderer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entity_pixel_renderer.sv
// Entity pixel renderer: 2-stage sprite-ROM/colour pipeline plus the PLAY/DYING/OVER game FSM.
// Optional feature macro GHOST_FRIGHT_EN adds the fright input (frightened-ghost sprite/palette).
module entity_pixel_renderer #(
  parameter int unsigned ANIM_DIV     = 8,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [6:0]  entity_code,
  input  logic [1:0]  entity_dir,
  input  logic [9:0]  entityX,
  input  logic [9:0]  entityY,
  input  logic        lose_game,
  input  logic        restart,
`ifdef GHOST_FRIGHT_EN
  input  logic        fright,
`endif
  output logic [13:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        pix_valid_out,
  output logic [1:0]  game_state
);

  typedef enum logic [1:0] {
    StPlay  = 2'd0,
    StDying = 2'd1,
    StOver  = 2'd2
  } state_e;

  localparam logic [6:0] CodeBg     = 7'd0;
  localparam logic [6:0] CodePacman = 7'd1;
  localparam logic [6:0] CodeMaze   = 7'd2;
  localparam logic [6:0] CodeBlinky = 7'd3;
  localparam logic [6:0] CodePinky  = 7'd4;
  localparam logic [6:0] CodeInky   = 7'd5;
  localparam logic [6:0] CodeClyde  = 7'd6;
  localparam logic [6:0] CodePellet = 7'd7;

  localparam logic [7:0] AnimLast  = 8'(ANIM_DIV - 1);
  localparam logic [7:0] DeathLoad = 8'(DEATH_FRAMES);

  logic        frame_clk_q;
  logic        frame_tick;
  state_e      state_q, state_d;
  logic [7:0]  death_cnt_q, death_cnt_d;
  logic [7:0]  anim_cnt_q, anim_cnt_d;
  logic        anim_frame_q, anim_frame_d;

  logic [9:0]  off_x, off_y;
  logic        unused_off;
  logic        rom_hit, ghost_hit, fright_hit;
  logic [2:0]  sprite_id, sel_id;
  logic [1:0]  sel_dir;
  logic [13:0] rom_addr_q, rom_addr_d;

  logic [6:0]  s1_code_q;
  logic        s1_valid_q;
  state_e      s1_state_q;
  logic        s1_dbit_q;
  logic        s1_fright_q;

  logic [23:0] pal_rgb;
  logic [23:0] rgb_d, rgb_q;
  logic        pix_valid_q;

  assign frame_tick = frame_clk & ~frame_clk_q;

  // Game-state FSM and animation counters
  always_comb begin
    state_d      = state_q;
    death_cnt_d  = death_cnt_q;
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
    unique case (state_q)
      StPlay: begin
        if (frame_tick) begin
          if (anim_cnt_q == AnimLast) begin
            anim_cnt_d   = 8'd0;
            anim_frame_d = ~anim_frame_q;
          end else begin
            anim_cnt_d = anim_cnt_q + 8'd1;
          end
        end
        if (lose_game && pixel_valid) begin
          state_d     = StDying;
          death_cnt_d = DeathLoad;
        end
      end
      StDying: begin
        if (restart) begin
          state_d      = StPlay;
          anim_cnt_d   = 8'd0;
          anim_frame_d = 1'b0;
        end else if (frame_tick) begin
          death_cnt_d = death_cnt_q - 8'd1;
          if (death_cnt_q == 8'd1) state_d = StOver;
        end
      end
      StOver: begin
        if (restart) begin
          state_d      = StPlay;
          anim_cnt_d   = 8'd0;
          anim_frame_d = 1'b0;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  // Stage 1: sprite ROM address generation
  assign off_x      = DrawX - entityX;
  assign off_y      = DrawY - entityY;
  assign unused_off = ^{off_x[9:4], off_y[9:4]};

  always_comb begin
    rom_hit   = 1'b1;
    ghost_hit = 1'b1;
    sprite_id = 3'd0;
    case (entity_code)
      CodePacman: ghost_hit = 1'b0;
      CodeBlinky: sprite_id = 3'd1;
      CodePinky:  sprite_id = 3'd2;
      CodeInky:   sprite_id = 3'd3;
      CodeClyde:  sprite_id = 3'd4;
      default: begin
        rom_hit   = 1'b0;
        ghost_hit = 1'b0;
      end
    endcase
  end

`ifdef GHOST_FRIGHT_EN
  assign fright_hit = fright & ghost_hit & (state_q == StPlay);
`else
  assign fright_hit = 1'b0;
`endif

  always_comb begin
    sel_id  = sprite_id;
    sel_dir = entity_dir;
    if (fright_hit) begin
      sel_id  = 3'd5;
      sel_dir = 2'd0;
    end
  end

  // Non-ROM codes keep the last address so the ROM bus stays quiet
  assign rom_addr_d = rom_hit ? {sel_id, anim_frame_q, sel_dir, off_y[3:0], off_x[3:0]}
                              : rom_addr_q;

  // Stage 2: palette lookup and per-state colour selection
  always_comb begin
    pal_rgb = 24'hFFFFFF;
    case (rom_data)
      4'd0:    pal_rgb = 24'h000000;
      4'd1:    pal_rgb = 24'hFFFF00;
      4'd2:    pal_rgb = 24'hFF0000;
      4'd3:    pal_rgb = 24'hFFB8FF;
      4'd4:    pal_rgb = 24'h00FFFF;
      4'd5:    pal_rgb = 24'hFFB852;
      4'd6:    pal_rgb = 24'hFFFFFF;
      4'd7:    pal_rgb = 24'h2121DE;
      default: pal_rgb = 24'hFFFFFF;
    endcase
    if (s1_fright_q && (rom_data == 4'd2)) pal_rgb = 24'h2121FF;
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (s1_valid_q) begin
      if (s1_state_q == StOver) begin
        rgb_d = 24'h404040;
      end else begin
        case (s1_code_q)
          CodeBg:     rgb_d = 24'h000000;
          CodeMaze:   rgb_d = 24'h2121DE;
          CodePellet: rgb_d = 24'hFFB8AE;
          // Dying pacman blinks on bit 2 of the death countdown
          CodePacman: if ((s1_state_q == StPlay) || s1_dbit_q) rgb_d = pal_rgb;
          CodeBlinky, CodePinky, CodeInky, CodeClyde: begin
            if (s1_state_q == StPlay) rgb_d = pal_rgb;
          end
          default:    rgb_d = 24'h000000;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q  <= 1'b0;
      state_q      <= StPlay;
      death_cnt_q  <= 8'd0;
      anim_cnt_q   <= 8'd0;
      anim_frame_q <= 1'b0;
      rom_addr_q   <= 14'd0;
      s1_code_q    <= 7'd0;
      s1_valid_q   <= 1'b0;
      s1_state_q   <= StPlay;
      s1_dbit_q    <= 1'b0;
      s1_fright_q  <= 1'b0;
      rgb_q        <= 24'h000000;
      pix_valid_q  <= 1'b0;
    end else begin
      frame_clk_q  <= frame_clk;
      state_q      <= state_d;
      death_cnt_q  <= death_cnt_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
      rom_addr_q   <= rom_addr_d;
      s1_code_q    <= entity_code;
      s1_valid_q   <= pixel_valid;
      s1_state_q   <= state_q;
      s1_dbit_q    <= death_cnt_q[2];
      s1_fright_q  <= fright_hit;
      rgb_q        <= rgb_d;
      pix_valid_q  <= s1_valid_q;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign Red           = rgb_q[23:16];
  assign Green         = rgb_q[15:8];
  assign Blue          = rgb_q[7:0];
  assign pix_valid_out = pix_valid_q;
  assign game_state    = state_q;

endmodule

// File: tb/tb_entity_pixel_renderer.sv
// Bench for entity_pixel_renderer: directed stimulus, a spec-level reference model compared every
// cycle, and literal expectations at key points. Honours GHOST_FRIGHT_EN when defined.
module tb_entity_pixel_renderer;

  localparam int unsigned AnimDiv     = 2;
  localparam int unsigned DeathFrames = 3;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, pixel_valid, lose_game, restart;
  logic [9:0]  DrawX, DrawY, entityX, entityY;
  logic [6:0]  entity_code;
  logic [1:0]  entity_dir;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data;
  logic [7:0]  Red, Green, Blue;
  logic        pix_valid_out;
  logic [1:0]  game_state;
  logic        fr_in;

  logic [3:0]  rom_mem [16384];
  int          n_err = 0;
  int          n_checks = 0;
  logic        cmp_en = 1'b0;

  always #5 Clk = ~Clk;

  assign rom_data = rom_mem[rom_addr];

`ifdef GHOST_FRIGHT_EN
  logic fright;
  assign fr_in = fright;
`else
  assign fr_in = 1'b0;
`endif

  entity_pixel_renderer #(
    .ANIM_DIV     (AnimDiv),
    .DEATH_FRAMES (DeathFrames)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .pixel_valid   (pixel_valid),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .entity_code   (entity_code),
    .entity_dir    (entity_dir),
    .entityX       (entityX),
    .entityY       (entityY),
    .lose_game     (lose_game),
    .restart       (restart),
`ifdef GHOST_FRIGHT_EN
    .fright        (fright),
`endif
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .Red           (Red),
    .Green         (Green),
    .Blue          (Blue),
    .pix_valid_out (pix_valid_out),
    .game_state    (game_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [23:0] m_pal(input logic [3:0] idx, input logic fr);
    logic [23:0] t [8];
    t = '{24'h000000, 24'hFFFF00, 24'hFF0000, 24'hFFB8FF,
          24'h00FFFF, 24'hFFB852, 24'hFFFFFF, 24'h2121DE};
    if (idx >= 4'd8) return 24'hFFFFFF;
    if (fr && idx == 4'd2) return 24'h2121FF;
    return t[idx[2:0]];
  endfunction

  function automatic logic [23:0] m_colour(input logic v, input logic [6:0] code,
                                           input logic [1:0] st, input logic dbit,
                                           input logic fr, input logic [3:0] idx);
    if (!v) return 24'h000000;
    if (st == 2'd2) return 24'h404040;
    if (code == 7'd2) return 24'h2121DE;
    if (code == 7'd7) return 24'hFFB8AE;
    if (code == 7'd1) return (st == 2'd1 && !dbit) ? 24'h000000 : m_pal(idx, fr);
    if (code >= 7'd3 && code <= 7'd6) return (st == 2'd1) ? 24'h000000 : m_pal(idx, fr);
    return 24'h000000;
  endfunction

  function automatic logic [13:0] m_address(input logic [2:0] id, input logic frame,
                                            input logic [1:0] dir, input logic [9:0] dx,
                                            input logic [9:0] dy, input logic [9:0] ex,
                                            input logic [9:0] ey);
    int ox, oy;
    ox = (int'(dx) - int'(ex)) & 15;
    oy = (int'(dy) - int'(ey)) & 15;
    return 14'(int'(id) * 2048 + int'(frame) * 1024 + int'(dir) * 256 + oy * 16 + ox);
  endfunction

  logic [1:0]  m_state;
  logic [7:0]  m_death, m_acnt;
  logic        m_aframe, m_fclk;
  logic [6:0]  m1_code;
  logic        m1_valid, m1_dbit, m1_fr;
  logic [1:0]  m1_state;
  logic [13:0] m_addr;
  logic [23:0] m_rgb;
  logic        m_pv;

  wire        m_tick  = frame_clk & ~m_fclk;
  wire        m_rom   = (entity_code == 7'd1) || (entity_code >= 7'd3 && entity_code <= 7'd6);
  wire        m_ghost = entity_code >= 7'd3 && entity_code <= 7'd6;
  wire        m_frhit = m_ghost && (m_state == 2'd0) && fr_in;
  wire [2:0]  m_sid   = m_frhit ? 3'd5 : (entity_code == 7'd1 ? 3'd0 : 3'(entity_code - 7'd2));
  wire [1:0]  m_dir   = m_frhit ? 2'd0 : entity_dir;

  always @(posedge Clk) begin
    if (Reset) begin
      m_state <= 2'd0; m_death <= 8'd0; m_acnt <= 8'd0; m_aframe <= 1'b0; m_fclk <= 1'b0;
      m1_code <= 7'd0; m1_valid <= 1'b0; m1_dbit <= 1'b0; m1_fr <= 1'b0; m1_state <= 2'd0;
      m_addr <= 14'd0; m_rgb <= 24'h0; m_pv <= 1'b0;
    end else begin
      m_fclk   <= frame_clk;
      m_pv     <= m1_valid;
      m_rgb    <= m_colour(m1_valid, m1_code, m1_state, m1_dbit, m1_fr, rom_mem[m_addr]);
      m1_code  <= entity_code;
      m1_valid <= pixel_valid;
      m1_state <= m_state;
      m1_dbit  <= m_death[2];
      m1_fr    <= m_frhit;
      if (m_rom) m_addr <= m_address(m_sid, m_aframe, m_dir, DrawX, DrawY, entityX, entityY);
      if (m_state == 2'd0) begin
        if (m_tick) begin
          if (int'(m_acnt) == AnimDiv - 1) begin
            m_acnt <= 8'd0; m_aframe <= ~m_aframe;
          end else m_acnt <= m_acnt + 8'd1;
        end
        if (lose_game && pixel_valid) begin
          m_state <= 2'd1; m_death <= 8'(DeathFrames);
        end
      end else if (restart) begin
        m_state <= 2'd0; m_acnt <= 8'd0; m_aframe <= 1'b0;
      end else if (m_state == 2'd1 && m_tick) begin
        m_death <= m_death - 8'd1;
        if (m_death == 8'd1) m_state <= 2'd2;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("model_rgb", {8'd0, Red, Green, Blue}, {8'd0, m_rgb});
      chk("model_pv", {31'd0, pix_valid_out}, {31'd0, m_pv});
      chk("model_addr", {18'd0, rom_addr}, {18'd0, m_addr});
      chk("model_state", {30'd0, game_state}, {30'd0, m_state});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic fedge(input int hi, input int lo);
    frame_clk = 1'b1; step(hi);
    frame_clk = 1'b0; step(lo);
  endtask

  function automatic logic [31:0] rgb32();
    return {8'd0, Red, Green, Blue};
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 16384; i++) rom_mem[i] = 4'(i * 7 + 3);
    rom_mem[14'h235] = 4'd1;
    rom_mem[14'hA35] = 4'd2;
    Reset = 1'b1; frame_clk = 1'b0; pixel_valid = 1'b0; lose_game = 1'b0; restart = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; entityX = 10'd0; entityY = 10'd0;
    entity_code = 7'd0; entity_dir = 2'd0;
`ifdef GHOST_FRIGHT_EN
    fright = 1'b0;
`endif
    step(1);
    cmp_en = 1'b1;
    step(2);
    chk("reset_rgb", rgb32(), 32'h0);
    chk("reset_pv", {31'd0, pix_valid_out}, 32'd0);
    chk("reset_state", {30'd0, game_state}, 32'd0);
    chk("reset_addr", {18'd0, rom_addr}, 32'd0);

    // maze pixel, 2-cycle latency
    Reset = 1'b0; pixel_valid = 1'b1; entity_code = 7'd2;
    step(1);
    chk("maze_pv_early", {31'd0, pix_valid_out}, 32'd0);
    step(1);
    chk("maze_pv", {31'd0, pix_valid_out}, 32'd1);
    chk("maze_rgb", rgb32(), 32'h2121DE);

    // pacman sprite address and palette
    entity_code = 7'd1; DrawX = 10'd105; entityX = 10'd100;
    DrawY = 10'd203; entityY = 10'd200; entity_dir = 2'd2;
    step(1);
    chk("pac_addr", {18'd0, rom_addr}, 32'h0235);
    step(1);
    chk("pac_rgb_idx1", rgb32(), 32'hFFFF00);
    rom_mem[14'h235] = 4'd0;
    step(1);
    chk("pac_rgb_idx0", rgb32(), 32'h000000);

    // pellet holds address; unknown code is background
    entity_code = 7'd7;
    step(2);
    chk("pellet_rgb", rgb32(), 32'hFFB8AE);
    chk("pellet_addr_hold", {18'd0, rom_addr}, 32'h0235);
    entity_code = 7'd9;
    step(2);
    chk("other_code_rgb", rgb32(), 32'h0);
    entity_code = 7'd3;
    step(2);
    chk("blinky_rgb", rgb32(), 32'hFF0000);

    // animation: long-high frame_clk is a single edge
    entity_code = 7'd1;
    fedge(10, 2);
    chk("anim_one_edge", {18'd0, rom_addr}, 32'h0235);
    fedge(2, 2);
    chk("anim_toggle1", {18'd0, rom_addr}, 32'h0635);
    fedge(2, 2); fedge(2, 2);
    chk("anim_toggle2", {18'd0, rom_addr}, 32'h0235);
    fedge(2, 2); fedge(2, 2);

    // restart ignored in PLAY
    restart = 1'b1; step(1); restart = 1'b0;
    chk("restart_play_state", {30'd0, game_state}, 32'd0);
    step(1);
    chk("restart_play_frame", {18'd0, rom_addr}, 32'h0635);

    // death sequence
    lose_game = 1'b1; step(1); lose_game = 1'b0;
    chk("dying_entered", {30'd0, game_state}, 32'd1);
    entity_code = 7'd3;
    step(2);
    chk("ghost_dying_black", rgb32(), 32'h0);
    lose_game = 1'b1; step(1); lose_game = 1'b0;
    chk("lose_in_dying", {30'd0, game_state}, 32'd1);
    fedge(1, 1); fedge(1, 1);
    chk("dying_two_ticks", {30'd0, game_state}, 32'd1);
    fedge(1, 1);
    chk("over_entered", {30'd0, game_state}, 32'd2);
    entity_code = 7'd0;
    step(2);
    chk("over_grey", rgb32(), 32'h404040);
    pixel_valid = 1'b0;
    step(2);
    chk("over_invalid", rgb32(), 32'h0);
    pixel_valid = 1'b1; entity_code = 7'd1;

    // restart from OVER clears animation frame
    restart = 1'b1; step(1); restart = 1'b0;
    chk("restart_over", {30'd0, game_state}, 32'd0);
    step(1);
    chk("restart_frame0", {18'd0, rom_addr}, 32'h0235);

    // restart with lose_game in DYING
    lose_game = 1'b1; step(1); lose_game = 1'b0;
    chk("dying_again", {30'd0, game_state}, 32'd1);
    restart = 1'b1; lose_game = 1'b1; step(1); restart = 1'b0; lose_game = 1'b0;
    chk("restart_beats_lose", {30'd0, game_state}, 32'd0);
    step(2);

    // reset mid-stream flushes the pipeline
    Reset = 1'b1; step(1);
    chk("reset_flush_pv", {31'd0, pix_valid_out}, 32'd0);
    Reset = 1'b0; step(3);

`ifdef GHOST_FRIGHT_EN
    fright = 1'b1; entity_code = 7'd4; entity_dir = 2'd3;
    step(1);
    chk("fright_id", {29'd0, rom_addr[13:11]}, 32'd5);
    chk("fright_dir", {30'd0, rom_addr[9:8]}, 32'd0);
    fright = 1'b0;
    step(2);
`endif

    cmp_en = 1'b0;
    step(1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
